// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// params_pkg / multicycle_ctrl
//
// Purpose: main sequencing FSM of the multi-cycle core. Each instruction walks
// FETCH -> DECODE -> EXECUTE -> (MEM) -> (WB). The block drives every datapath
// enable and mux select, including the shared ALU operands and opcode. It also
// runs the single-port memory handshake, resolves branches from the ALU flags,
// counts retired instructions, and stops the core on SYSTEM or an illegal
// opcode.
//
// Ports:
//   clk_i, rst_ni             core clock; asynchronous active-low reset
//   opcode_i, funct3_i        decoded opcode / funct3 of the instruction reg
//   alu_zero_i, alu_less_i    ALU is_zero / is_less flags
//   mem_ready_i               memory completes the current request this cycle
//   mem_req_o, mem_we_o       memory request / write strobe
//   addr_sel_o                memory address: 0 = PC, 1 = ALUOUT
//   ir_we_o, mdr_we_o         load IR+OLDPC / load memory-data register
//   pc_we_o, pc_sel_o         PC write; source 0 = live ALU, 1 = ALUOUT
//   alu_a_sel_o               0 = regA, 1 = PC, 2 = OLDPC, 3 = zero
//   alu_b_sel_o               0 = regB, 1 = immediate, 2 = constant 4
//   alu_op_o                  opcode presented to the ALU (LOAD = add)
//   rf_we_o, wb_sel_o         reg-file write; source 0 = ALUOUT, 1 = MDR, 2 = PC
//   halt_o, illegal_o         core stopped; stop caused by illegal opcode
//   instret_o                 retired-instruction counter (wraps)
// ---------------------------------------------------------------------------
package params_pkg;

    // Encodings 9..15 are unassigned and decode as illegal.
    typedef enum logic [3:0] {
        R         = 4'd0,
        IMMEDIATE = 4'd1,
        LOAD      = 4'd2,
        STORE     = 4'd3,
        BRANCH    = 4'd4,
        JAL       = 4'd5,
        LUI       = 4'd6,
        AUIPC     = 4'd7,
        SYSTEM    = 4'd8
    } opcode;

endpackage

module multicycle_ctrl
    import params_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  opcode                 opcode_i,
    input  logic [2:0]            funct3_i,
    input  logic                  alu_zero_i,
    input  logic                  alu_less_i,
    input  logic                  mem_ready_i,
    output logic                  mem_req_o,
    output logic                  mem_we_o,
    output logic                  addr_sel_o,
    output logic                  ir_we_o,
    output logic                  mdr_we_o,
    output logic                  pc_we_o,
    output logic                  pc_sel_o,
    output logic [1:0]            alu_a_sel_o,
    output logic [1:0]            alu_b_sel_o,
    output opcode                 alu_op_o,
    output logic                  rf_we_o,
    output logic [1:0]            wb_sel_o,
    output logic                  halt_o,
    output logic                  illegal_o,
    output logic [DATA_WIDTH-1:0] instret_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_MEM,
        ST_WB,
        ST_HALT
    } state_t;

    // Select encodings
    localparam logic [1:0] A_REGA  = 2'd0;
    localparam logic [1:0] A_PC    = 2'd1;
    localparam logic [1:0] A_OLDPC = 2'd2;
    localparam logic [1:0] A_ZERO  = 2'd3;
    localparam logic [1:0] B_REGB  = 2'd0;
    localparam logic [1:0] B_IMM   = 2'd1;
    localparam logic [1:0] B_FOUR  = 2'd2;
    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_MDR  = 2'd1;
    localparam logic [1:0] WB_PC   = 2'd2;

    state_t                state_q,   state_d;
    logic                  illegal_q, illegal_d;
    logic [DATA_WIDTH-1:0] instret_q, instret_d;
    logic                  retire;
    logic                  branch_taken;
    logic                  opcode_legal;

    // Branch resolution from the flags of the compare done in EXECUTE.
    always_comb begin
        unique case (funct3_i)
            3'b000:  branch_taken = alu_zero_i;   // BEQ
            3'b001:  branch_taken = !alu_zero_i;  // BNE
            3'b100:  branch_taken = alu_less_i;   // BLT
            3'b101:  branch_taken = !alu_less_i;  // BGE
            default: branch_taken = 1'b0;
        endcase
    end

    assign opcode_legal = opcode_i inside {R, IMMEDIATE, LOAD, STORE, BRANCH,
                                           JAL, LUI, AUIPC, SYSTEM};

    // Outputs are a Moore decode of state_q qualified by the live inputs, so
    // an asynchronous reset (state_q -> IDLE) drops any outstanding request
    // immediately.
    always_comb begin
        state_d     = state_q;
        illegal_d   = illegal_q;
        retire      = 1'b0;

        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        addr_sel_o  = 1'b0;
        ir_we_o     = 1'b0;
        mdr_we_o    = 1'b0;
        pc_we_o     = 1'b0;
        pc_sel_o    = 1'b0;
        alu_a_sel_o = A_REGA;
        alu_b_sel_o = B_REGB;
        alu_op_o    = LOAD;
        rf_we_o     = 1'b0;
        wb_sel_o    = WB_ALU;
        halt_o      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end

            // PC+4 is computed on the ALU while the instruction is read.
            ST_FETCH: begin
                mem_req_o   = 1'b1;
                addr_sel_o  = 1'b0;
                alu_a_sel_o = A_PC;
                alu_b_sel_o = B_FOUR;
                if (mem_ready_i) begin
                    ir_we_o  = 1'b1;
                    pc_we_o  = 1'b1;
                    pc_sel_o = 1'b0;
                    state_d  = ST_DECODE;
                end
            end

            // Speculatively compute OLDPC+imm into ALUOUT: the branch/JAL
            // target used by EXECUTE through pc_sel_o = 1.
            ST_DECODE: begin
                alu_a_sel_o = A_OLDPC;
                alu_b_sel_o = B_IMM;
                if (opcode_legal) begin
                    state_d = ST_EXECUTE;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = ST_HALT;
                end
            end

            ST_EXECUTE: begin
                unique case (opcode_i)
                    R: begin
                        alu_a_sel_o = A_REGA;
                        alu_b_sel_o = B_REGB;
                        alu_op_o    = R;
                        state_d     = ST_WB;
                    end
                    IMMEDIATE: begin
                        alu_a_sel_o = A_REGA;
                        alu_b_sel_o = B_IMM;
                        alu_op_o    = IMMEDIATE;
                        state_d     = ST_WB;
                    end
                    LUI: begin
                        alu_a_sel_o = A_ZERO;
                        alu_b_sel_o = B_IMM;
                        alu_op_o    = LUI;
                        state_d     = ST_WB;
                    end
                    AUIPC: begin
                        alu_a_sel_o = A_OLDPC;
                        alu_b_sel_o = B_IMM;
                        alu_op_o    = AUIPC;
                        state_d     = ST_WB;
                    end
                    LOAD, STORE: begin
                        alu_a_sel_o = A_REGA;
                        alu_b_sel_o = B_IMM;
                        alu_op_o    = LOAD;
                        state_d     = ST_MEM;
                    end
                    BRANCH: begin
                        alu_a_sel_o = A_REGA;
                        alu_b_sel_o = B_REGB;
                        alu_op_o    = BRANCH;
                        if (branch_taken) begin
                            pc_we_o  = 1'b1;
                            pc_sel_o = 1'b1;
                        end
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end
                    // PC already holds OLDPC+4 (the link value); the register
                    // file samples it on the same edge the PC takes the target.
                    JAL: begin
                        rf_we_o  = 1'b1;
                        wb_sel_o = WB_PC;
                        pc_we_o  = 1'b1;
                        pc_sel_o = 1'b1;
                        retire   = 1'b1;
                        state_d  = ST_FETCH;
                    end
                    SYSTEM: begin
                        retire  = 1'b1;
                        state_d = ST_HALT;
                    end
                    // IR is stable after DECODE; reaching here means the
                    // opcode changed underneath us, so stop as illegal.
                    default: begin
                        illegal_d = 1'b1;
                        state_d   = ST_HALT;
                    end
                endcase
            end

            ST_MEM: begin
                mem_req_o  = 1'b1;
                addr_sel_o = 1'b1;
                mem_we_o   = (opcode_i == STORE);
                if (mem_ready_i) begin
                    if (opcode_i == STORE) begin
                        retire  = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        mdr_we_o = 1'b1;
                        state_d  = ST_WB;
                    end
                end
            end

            ST_WB: begin
                rf_we_o  = 1'b1;
                wb_sel_o = (opcode_i == LOAD) ? WB_MDR : WB_ALU;
                retire   = 1'b1;
                state_d  = ST_FETCH;
            end

            ST_HALT: begin
                halt_o = 1'b1;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        instret_d = retire ? (instret_q + DATA_WIDTH'(1)) : instret_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            illegal_q <= 1'b0;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            instret_q <= instret_d;
        end
    end

    assign illegal_o = illegal_q;
    assign instret_o = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multicycle_ctrl
//
// Directed bench for multicycle_ctrl. Outputs are packed into one vector and
// compared per cycle against hand-written expected vectors; instret_o and
// cycle latencies are compared separately.
// ---------------------------------------------------------------------------
module tb_multicycle_ctrl;
    import params_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b1;
    opcode       opcode_i = R;
    logic [2:0]  funct3_i = 3'b000;
    logic        alu_zero_i = 1'b0;
    logic        alu_less_i = 1'b0;
    logic        mem_ready_i = 1'b1;
    logic        mem_req_o, mem_we_o, addr_sel_o, ir_we_o, mdr_we_o;
    logic        pc_we_o, pc_sel_o, rf_we_o, halt_o, illegal_o;
    logic [1:0]  alu_a_sel_o, alu_b_sel_o, wb_sel_o;
    opcode       alu_op_o;
    logic [31:0] instret_o;

    multicycle_ctrl #(.DATA_WIDTH(32)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .opcode_i    (opcode_i),
        .funct3_i    (funct3_i),
        .alu_zero_i  (alu_zero_i),
        .alu_less_i  (alu_less_i),
        .mem_ready_i (mem_ready_i),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .addr_sel_o  (addr_sel_o),
        .ir_we_o     (ir_we_o),
        .mdr_we_o    (mdr_we_o),
        .pc_we_o     (pc_we_o),
        .pc_sel_o    (pc_sel_o),
        .alu_a_sel_o (alu_a_sel_o),
        .alu_b_sel_o (alu_b_sel_o),
        .alu_op_o    (alu_op_o),
        .rf_we_o     (rf_we_o),
        .wb_sel_o    (wb_sel_o),
        .halt_o      (halt_o),
        .illegal_o   (illegal_o),
        .instret_o   (instret_o)
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;
    int cycle    = 0;
    int start;
    int req_seen;

    logic [19:0] outs;
    assign outs = {mem_req_o, mem_we_o, addr_sel_o, ir_we_o, mdr_we_o, pc_we_o,
                   pc_sel_o, alu_a_sel_o, alu_b_sel_o, alu_op_o, rf_we_o,
                   wb_sel_o, halt_o, illegal_o};

    function automatic logic [19:0] ov(
        input logic req, we, asel, irwe, mdrwe, pcwe, pcsel,
        input logic [1:0] a, b, input opcode op, input logic rfwe,
        input logic [1:0] wb, input logic halt, ill);
        return {req, we, asel, irwe, mdrwe, pcwe, pcsel, a, b, op, rfwe, wb, halt, ill};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic co(input string tag, input logic [19:0] exp);
        check(tag, 32'(outs), 32'(exp));
    endtask

    task automatic ci(input string tag, input logic [31:0] exp);
        check(tag, instret_o, exp);
    endtask

    // One clock: inputs for the new cycle are applied 1 time unit after the
    // rising edge, outputs are sampled 1 unit later.
    task automatic cyc(input logic rdy);
        @(posedge clk_i);
        #1;
        mem_ready_i = rdy;
        cycle++;
        #1;
    endtask

    logic [19:0] E_DEF, E_FWAIT, E_FGO, E_DEC, E_EX_R, E_EX_I, E_EX_LUI, E_EX_AUI;
    logic [19:0] E_EX_LS, E_EX_BT, E_EX_BN, E_EX_JAL, E_MEM_LW, E_MEM_LR, E_MEM_SW;
    logic [19:0] E_WB_ALU, E_WB_LD, E_HALT, E_HALT_ILL;

    initial begin
        //            req we as ir mdr pcwe pcsel a  b  op         rf wb halt ill
        E_DEF      = ov(0, 0, 0, 0, 0, 0, 0, 0, 0, LOAD,      0, 0, 0, 0);
        E_FWAIT    = ov(1, 0, 0, 0, 0, 0, 0, 1, 2, LOAD,      0, 0, 0, 0);
        E_FGO      = ov(1, 0, 0, 1, 0, 1, 0, 1, 2, LOAD,      0, 0, 0, 0);
        E_DEC      = ov(0, 0, 0, 0, 0, 0, 0, 2, 1, LOAD,      0, 0, 0, 0);
        E_EX_R     = ov(0, 0, 0, 0, 0, 0, 0, 0, 0, R,         0, 0, 0, 0);
        E_EX_I     = ov(0, 0, 0, 0, 0, 0, 0, 0, 1, IMMEDIATE, 0, 0, 0, 0);
        E_EX_LUI   = ov(0, 0, 0, 0, 0, 0, 0, 3, 1, LUI,       0, 0, 0, 0);
        E_EX_AUI   = ov(0, 0, 0, 0, 0, 0, 0, 2, 1, AUIPC,     0, 0, 0, 0);
        E_EX_LS    = ov(0, 0, 0, 0, 0, 0, 0, 0, 1, LOAD,      0, 0, 0, 0);
        E_EX_BT    = ov(0, 0, 0, 0, 0, 1, 1, 0, 0, BRANCH,    0, 0, 0, 0);
        E_EX_BN    = ov(0, 0, 0, 0, 0, 0, 0, 0, 0, BRANCH,    0, 0, 0, 0);
        E_EX_JAL   = ov(0, 0, 0, 0, 0, 1, 1, 0, 0, LOAD,      1, 2, 0, 0);
        E_MEM_LW   = ov(1, 0, 1, 0, 0, 0, 0, 0, 0, LOAD,      0, 0, 0, 0);
        E_MEM_LR   = ov(1, 0, 1, 0, 1, 0, 0, 0, 0, LOAD,      0, 0, 0, 0);
        E_MEM_SW   = ov(1, 1, 1, 0, 0, 0, 0, 0, 0, LOAD,      0, 0, 0, 0);
        E_WB_ALU   = ov(0, 0, 0, 0, 0, 0, 0, 0, 0, LOAD,      1, 0, 0, 0);
        E_WB_LD    = ov(0, 0, 0, 0, 0, 0, 0, 0, 0, LOAD,      1, 1, 0, 0);
        E_HALT     = ov(0, 0, 0, 0, 0, 0, 0, 0, 0, LOAD,      0, 0, 1, 0);
        E_HALT_ILL = ov(0, 0, 0, 0, 0, 0, 0, 0, 0, LOAD,      0, 0, 1, 1);

        // ---- reset ----
        #1 rst_ni = 1'b0;
        #1;
        co("rst_outs", E_DEF);
        ci("rst_instret", 32'd0);
        cyc(1);
        co("rst_held", E_DEF);
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        co("idle", E_DEF);

        // ---- R-type, zero wait ----
        cyc(1); opcode_i = R; start = cycle;
        co("r_fetch", E_FGO);
        cyc(1); co("r_dec", E_DEC);
        cyc(1); co("r_ex", E_EX_R);
        cyc(1); co("r_wb", E_WB_ALU); ci("r_inst_pre", 32'd0);

        // ---- LOAD: 3 FETCH waits, 2 MEM waits ----
        cyc(0); opcode_i = LOAD;
        co("r_next_req", E_FWAIT);
        check("r_latency", 32'(cycle - start), 32'd4);
        ci("r_inst", 32'd1);
        start = cycle;
        cyc(0); co("lw_fw1", E_FWAIT);
        cyc(0); co("lw_fw2", E_FWAIT);
        cyc(1); co("lw_fgo", E_FGO);
        cyc(1); co("lw_dec", E_DEC);
        cyc(1); co("lw_ex", E_EX_LS);
        cyc(0); co("lw_mw0", E_MEM_LW);
        cyc(0); co("lw_mw1", E_MEM_LW);
        cyc(1); co("lw_mrdy", E_MEM_LR);
        cyc(1); co("lw_wb", E_WB_LD);

        // ---- BRANCH beq taken ----
        cyc(1); opcode_i = BRANCH; funct3_i = 3'b000; alu_zero_i = 1'b1; alu_less_i = 1'b0;
        check("lw_latency", 32'(cycle - start), 32'd10);
        ci("lw_inst", 32'd2);
        start = cycle;
        cyc(1); co("beq_dec", E_DEC);
        cyc(1); co("beq_ex", E_EX_BT);

        // ---- BRANCH bge with less=1: not taken ----
        cyc(1); funct3_i = 3'b101; alu_zero_i = 1'b0; alu_less_i = 1'b1;
        co("beq_fetch", E_FGO);
        check("beq_latency", 32'(cycle - start), 32'd3);
        ci("beq_inst", 32'd3);
        cyc(1); co("bge_dec", E_DEC);
        cyc(1); co("bge_ex", E_EX_BN);

        // ---- BRANCH unsupported funct3 with both flags set: not taken ----
        cyc(1); funct3_i = 3'b010; alu_zero_i = 1'b1; alu_less_i = 1'b1;
        ci("bge_inst", 32'd4);
        cyc(1);
        cyc(1); co("b010_ex", E_EX_BN);

        // ---- JAL ----
        cyc(1); opcode_i = JAL; start = cycle;
        ci("b010_inst", 32'd5);
        cyc(1); co("jal_dec", E_DEC);
        cyc(1); co("jal_ex", E_EX_JAL);

        // ---- STORE, zero wait ----
        cyc(1); opcode_i = STORE;
        co("jal_fetch", E_FGO);
        check("jal_latency", 32'(cycle - start), 32'd3);
        ci("jal_inst", 32'd6);
        start = cycle;
        cyc(1); co("sw_dec", E_DEC);
        cyc(1); co("sw_ex", E_EX_LS);
        cyc(1); co("sw_mem", E_MEM_SW);

        // ---- SYSTEM: halt, retired ----
        cyc(1); opcode_i = SYSTEM;
        check("sw_latency", 32'(cycle - start), 32'd4);
        ci("sw_inst", 32'd7);
        cyc(1); co("sys_dec", E_DEC);
        cyc(1); co("sys_ex", E_DEF);
        cyc(1); co("sys_halt", E_HALT); ci("sys_inst", 32'd8);
        req_seen = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            if (mem_req_o || !halt_o) req_seen++;
        end
        check("sys_stays_halted", 32'(req_seen), 32'd0);

        // ---- reset from HALT, then STORE interrupted in MEM ----
        #2 rst_ni = 1'b0;
        #1;
        co("rst_from_halt", E_DEF);
        ci("rst_from_halt_inst", 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        co("idle2", E_DEF);
        cyc(1); opcode_i = STORE;
        co("sw2_fetch", E_FGO);
        cyc(1);
        cyc(1);
        cyc(0); co("sw2_mw0", E_MEM_SW);
        cyc(0); co("sw2_mw1", E_MEM_SW);
        #2 rst_ni = 1'b0;
        #1;
        check("mid_mem_req", 32'(mem_req_o), 32'd0);
        check("mid_mem_we", 32'(mem_we_o), 32'd0);
        ci("mid_mem_inst", 32'd0);
        cyc(1);

        // ---- restart, one R retire, then illegal opcode ----
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        co("idle3", E_DEF);
        cyc(1); opcode_i = R;
        co("r2_fetch", E_FGO);
        cyc(1); cyc(1); cyc(1);
        cyc(1); opcode_i = opcode'(4'hF);
        ci("r2_inst", 32'd1);
        cyc(1); co("ill_dec", E_DEC);
        cyc(1); co("ill_halt", E_HALT_ILL); ci("ill_inst", 32'd1);
        req_seen = 0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (mem_req_o) req_seen++;
        end
        check("ill_no_req", 32'(req_seen), 32'd0);
        co("ill_sticky", E_HALT_ILL);

        // ---- reset clears illegal; instret wrap through LUI/AUIPC/IMMEDIATE ----
        #2 rst_ni = 1'b0;
        #1;
        co("rst_clears_ill", E_DEF);
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        force dut.instret_q = 32'hFFFF_FFFE;
        #1;
        release dut.instret_q;
        ci("wrap_preload", 32'hFFFF_FFFE);
        cyc(1); opcode_i = LUI;
        cyc(1);
        cyc(1); co("lui_ex", E_EX_LUI);
        cyc(1); co("lui_wb", E_WB_ALU);
        cyc(1); opcode_i = AUIPC;
        ci("wrap_max", 32'hFFFF_FFFF);
        cyc(1);
        cyc(1); co("auipc_ex", E_EX_AUI);
        cyc(1);
        cyc(1); opcode_i = IMMEDIATE;
        ci("wrap_zero", 32'd0);
        cyc(1);
        cyc(1); co("imm_ex", E_EX_I);
        cyc(1); co("imm_wb", E_WB_ALU);
        cyc(1);
        ci("wrap_one", 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Main sequencing FSM of the multi-cycle core. Each instruction passes through FETCH / DECODE / EXECUTE / MEM / WB, and this block drives every datapath enable and mux select, including the shared ALU's operands and opcode. It also runs the single-port memory handshake, resolves branches from the ALU flags, retires instructions and handles halt and illegal-opcode stops.

## Interface
- `DATA_WIDTH`, default 32: width of `instret_o`.
- `clk_i`  in  1  core clock.
- `rst_ni`  in  1  reset; asynchronous assert, active-low.
- `opcode_i`  in  `opcode` (params_pkg enum)  decoded opcode of the instruction register; the enum includes `BRANCH`.
- `funct3_i`  in  3  funct3 field of the instruction register.
- `alu_zero_i`, `alu_less_i`  in  1 each  ALU `is_zero` / `is_less` flags.
- `mem_ready_i`  in  1  memory completes the current request this cycle.
- `mem_req_o`, `mem_we_o`  out  1 each  memory request; write strobe.
- `addr_sel_o`  out  1  memory address source: 0 = PC, 1 = ALUOUT register.
- `ir_we_o`  out  1  load IR and OLDPC from memory data / PC.
- `mdr_we_o`  out  1  load the memory-data register.
- `pc_we_o`  out  1  PC write enable.
- `pc_sel_o`  out  1  PC source: 0 = live ALU result, 1 = ALUOUT register.
- `alu_a_sel_o`  out  2  0 = regA, 1 = PC, 2 = OLDPC, 3 = zero.
- `alu_b_sel_o`  out  2  0 = regB, 1 = immediate, 2 = constant 4.
- `alu_op_o`  out  `opcode`  opcode presented to the ALU.
- `rf_we_o`  out  1  register-file write enable.
- `wb_sel_o`  out  2  write-back source: 0 = ALUOUT, 1 = MDR, 2 = PC.
- `halt_o`, `illegal_o`  out  1 each  core stopped; stop caused by an illegal opcode.
- `instret_o`  out  `DATA_WIDTH`  retired-instruction counter.

## Operation
- ALUOUT is written every cycle by the datapath.
- States: IDLE, FETCH, DECODE, EXECUTE, MEM, WB, HALT. Outputs are a Moore decode of the state, plus `mem_ready_i`, `opcode_i`, `funct3_i` and the flags.
- **Default output values:** all 1-bit outputs 0, all selects 0, `alu_op_o = LOAD` (ALU add).
- **IDLE:** entered only from reset; all outputs at default; goes to FETCH next cycle.
- **FETCH:** `mem_req_o=1`, `addr_sel_o=0`, `alu_a_sel_o=1`, `alu_b_sel_o=2`.
  - When `mem_ready_i=1`: `ir_we_o=1`, `pc_we_o=1`, `pc_sel_o=0` (PC <= PC+4), then DECODE.
  - Otherwise stay in FETCH, holding all outputs.
- **DECODE:** `alu_a_sel_o=2`, `alu_b_sel_o=1` (ALUOUT <= OLDPC+imm, the branch/JAL target).
  - Opcode not in {R, IMMEDIATE, LOAD, STORE, BRANCH, JAL, LUI, AUIPC, SYSTEM}: set sticky `illegal_o`, go to HALT.
  - Otherwise go to EXECUTE.
- **EXECUTE**, by opcode:
  - R: a=regA, b=regB, op=R; then WB.
  - IMMEDIATE: a=regA, b=imm, op=IMMEDIATE; then WB.
  - LUI: a=zero, b=imm, op=LUI; then WB.
  - AUIPC: a=OLDPC, b=imm, op=AUIPC; then WB.
  - LOAD / STORE: a=regA, b=imm, op=LOAD; then MEM.
  - BRANCH: a=regA, b=regB, op=BRANCH.
    - Taken when: funct3 000 and zero; 001 and !zero; 100 and less; 101 and !less. Any other funct3 is not taken.
    - If taken: `pc_we_o=1`, `pc_sel_o=1`.
    - Retire, then FETCH.
  - JAL: `rf_we_o=1`, `wb_sel_o=2` (rd <= PC, already OLDPC+4), `pc_we_o=1`, `pc_sel_o=1`. Retire, then FETCH.
  - SYSTEM: retire, then HALT.
- **MEM:** `mem_req_o=1`, `addr_sel_o=1`, `mem_we_o=1` for STORE.
  - Hold until `mem_ready_i`.
  - On ready: STORE retires and goes to FETCH; LOAD asserts `mdr_we_o` and goes to WB.
- **WB:** `rf_we_o=1`, `wb_sel_o=1` for LOAD, 0 otherwise. Retire, then FETCH.
- **HALT:** `halt_o=1`, all other outputs at default. Left only by reset.
- **Retire:** `instret_o` increments by 1 on the retiring edge and wraps modulo 2^DATA_WIDTH.

## Timing
- **Reset:** asynchronous on `rst_ni` low.
  - State = IDLE, `instret_o=0`, `illegal_o=0`; every output is at its default while reset is low.
  - First `mem_req_o` appears in the second cycle after `rst_ni` rises.
  - Reset mid-operation (e.g. in MEM with a request outstanding) drops `mem_req_o` immediately. No retire is counted for the interrupted instruction.
- **Memory handshake:** the request completes in the cycle where `mem_req_o && mem_ready_i`. While waiting, `mem_req_o`, `mem_we_o` and `addr_sel_o` stay stable. `mem_ready_i` is ignored when `mem_req_o=0`.
- **Latency with zero wait states:**
  - R / IMMEDIATE / LUI / AUIPC: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - BRANCH / JAL: 3 cycles.
  - Each memory wait cycle adds 1.
- **Same-edge effects:** in JAL, the register-file write and PC write share one edge, and the register file samples the pre-edge PC. `instret_o` is visible the cycle after the retiring state.

## Test plan
- **R-type, zero wait:** reset release, `mem_ready_i=1`, `opcode_i=R` → states IDLE, FETCH, DECODE, EXECUTE, WB. Exactly one `rf_we_o` pulse with `wb_sel_o=0`; `instret_o` 0→1; next `mem_req_o` 4 cycles after the first.
- **LOAD with wait states:** `mem_ready_i` low for 3 cycles in FETCH and 2 in MEM → `mem_req_o` stable throughout, `addr_sel_o` 0 then 1, `mdr_we_o` for one cycle, `wb_sel_o=1`. Total 10 cycles.
- **BRANCH:** funct3 000 with zero=1 → `pc_we_o=1`, `pc_sel_o=1` in EXECUTE. Funct3 101 with less=1 → no `pc_we_o`. Both retire.
- **JAL:** EXECUTE cycle shows `rf_we_o=1`, `wb_sel_o=2`, `pc_we_o=1`, `pc_sel_o=1`; returns to FETCH after 3 cycles.
- **Stops:** an illegal opcode in DECODE → `illegal_o=1`, `halt_o=1`, `instret_o` unchanged, no further `mem_req_o` for 20 cycles. SYSTEM → `halt_o=1`, `illegal_o=0`, `instret_o` +1.
- **Reset mid-MEM of a STORE:** assert `rst_ni=0` mid-cycle → `mem_req_o` and `mem_we_o` drop asynchronously and `instret_o=0`. After release the sequence restarts at IDLE; force `instret_o` near 2^32-1 and confirm it wraps to 0.
